// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM states, requester ids and the round-robin pick.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_MEM   = 1'b1
  } requester_t;

  // On contention the requester that did not win last time is chosen.
  function automatic requester_t rr_pick(input logic fetch_req, input logic mem_req,
                                         input requester_t last_grant);
    if (fetch_req && mem_req)
      return (last_grant == REQ_FETCH) ? REQ_MEM : REQ_FETCH;
    else if (mem_req)
      return REQ_MEM;
    else
      return REQ_FETCH;
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Counts cycles while enabled and pulses o_expired on the cycle that completes TIMEOUT_CYCLES.
// TIMEOUT_CYCLES = 0 disables the watchdog; the counter saturates rather than wrapping.
module arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int            CW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_inc;
  logic          w_sat;

  assign w_count_inc = r_count + CW'(1);
  assign w_sat       = (r_count == LIMIT);

  always_ff @(posedge i_clk) begin
    if (!i_reset || i_clear)
      r_count <= '0;
    else if (i_enable && !w_sat)
      r_count <= w_count_inc;
  end

  assign o_expired = (TIMEOUT_CYCLES > 0) && i_enable && !w_sat && (w_count_inc == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one external memory port between the fetch and memory stages.
//   IDLE | waiting for a request; grant chosen and bus registers loaded on exit
//   BUSY | bus_req high, waiting for bus_ack or watchdog expiry
//   DONE | granted done high with read data; left when the granted request drops
//   FAULT| granted done and fault high, read data zero; left like DONE
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_fetch_req,
  input  logic [ADDR_WIDTH-1:0]   i_fetch_addr,
  output logic                    o_fetch_done,
  output logic [DATA_WIDTH-1:0]   o_fetch_rdata,
  input  logic                    i_mem_req,
  input  logic                    i_mem_we,
  input  logic [ADDR_WIDTH-1:0]   i_mem_addr,
  input  logic [DATA_WIDTH-1:0]   i_mem_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_mem_mask,
  output logic                    o_mem_done,
  output logic [DATA_WIDTH-1:0]   o_mem_rdata,
  output logic                    o_fault,
  output logic                    o_bus_req,
  output logic                    o_bus_we,
  output logic [ADDR_WIDTH-1:0]   o_bus_addr,
  output logic [DATA_WIDTH-1:0]   o_bus_wdata,
  output logic [DATA_WIDTH/8-1:0] o_bus_mask,
  input  logic                    i_bus_ack,
  input  logic [DATA_WIDTH-1:0]   i_bus_rdata
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  requester_t r_grant;
  requester_t r_last_grant;
  requester_t w_pick;

  logic                    r_bus_we;
  logic [ADDR_WIDTH-1:0]   r_bus_addr;
  logic [DATA_WIDTH-1:0]   r_bus_wdata;
  logic [DATA_WIDTH/8-1:0] r_bus_mask;
  logic [DATA_WIDTH-1:0]   r_rdata;

  logic w_load;
  logic w_capture;
  logic w_granted_req;
  logic w_expired;
  logic w_done_any;

  arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (r_state == IDLE),
    .i_enable (r_state == BUSY),
    .o_expired(w_expired)
  );

  assign w_pick        = rr_pick(i_fetch_req, i_mem_req, r_last_grant);
  assign w_granted_req = (r_grant == REQ_MEM) ? i_mem_req : i_fetch_req;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_fetch_req || i_mem_req) begin
          w_state_nxt = BUSY;
          w_load      = 1'b1;
        end
      end
      BUSY: begin
        // A late ack on the expiry cycle still counts as a completed transaction.
        if (i_bus_ack) begin
          w_state_nxt = DONE;
          w_capture   = 1'b1;
        end else if (w_expired) begin
          w_state_nxt = FAULT;
        end
      end
      DONE, FAULT: begin
        if (!w_granted_req)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= IDLE;
      r_grant      <= REQ_FETCH;
      r_last_grant <= REQ_FETCH;
      r_bus_we     <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_wdata  <= '0;
      r_bus_mask   <= '0;
      r_rdata      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_grant      <= w_pick;
        r_last_grant <= w_pick;
        if (w_pick == REQ_MEM) begin
          r_bus_we    <= i_mem_we;
          r_bus_addr  <= i_mem_addr;
          r_bus_wdata <= i_mem_wdata;
          r_bus_mask  <= i_mem_mask;
        end else begin
          r_bus_we    <= 1'b0;
          r_bus_addr  <= i_fetch_addr;
          r_bus_wdata <= '0;
          r_bus_mask  <= '0;
        end
      end
      if (w_capture)
        r_rdata <= i_bus_rdata;
    end
  end

  assign w_done_any    = (r_state == DONE) || (r_state == FAULT);
  assign o_fetch_done  = w_done_any && (r_grant == REQ_FETCH);
  assign o_mem_done    = w_done_any && (r_grant == REQ_MEM);
  assign o_fault       = (r_state == FAULT);
  assign o_fetch_rdata = (r_state == DONE && r_grant == REQ_FETCH) ? r_rdata : '0;
  assign o_mem_rdata   = (r_state == DONE && r_grant == REQ_MEM) ? r_rdata : '0;
  assign o_bus_req     = (r_state == BUSY);
  assign o_bus_we      = r_bus_we;
  assign o_bus_addr    = r_bus_addr;
  assign o_bus_wdata   = r_bus_wdata;
  assign o_bus_mask    = r_bus_mask;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level model checked every cycle plus literal checks.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MW  = DW / 8;
  localparam int TMO = 4;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_fetch_req;
  logic [AW-1:0] i_fetch_addr;
  logic          o_fetch_done;
  logic [DW-1:0] o_fetch_rdata;
  logic          i_mem_req;
  logic          i_mem_we;
  logic [AW-1:0] i_mem_addr;
  logic [DW-1:0] i_mem_wdata;
  logic [MW-1:0] i_mem_mask;
  logic          o_mem_done;
  logic [DW-1:0] o_mem_rdata;
  logic          o_fault;
  logic          o_bus_req;
  logic          o_bus_we;
  logic [AW-1:0] o_bus_addr;
  logic [DW-1:0] o_bus_wdata;
  logic [MW-1:0] o_bus_mask;
  logic          i_bus_ack;
  logic [DW-1:0] i_bus_rdata;

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_on = 1'b0;

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_fetch_req(i_fetch_req), .i_fetch_addr(i_fetch_addr),
    .o_fetch_done(o_fetch_done), .o_fetch_rdata(o_fetch_rdata),
    .i_mem_req(i_mem_req), .i_mem_we(i_mem_we), .i_mem_addr(i_mem_addr),
    .i_mem_wdata(i_mem_wdata), .i_mem_mask(i_mem_mask),
    .o_mem_done(o_mem_done), .o_mem_rdata(o_mem_rdata), .o_fault(o_fault),
    .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
    .o_bus_wdata(o_bus_wdata), .o_bus_mask(o_bus_mask),
    .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one outstanding transaction, owned by fetch (0) or mem (1).
  bit          m_active, m_done, m_fault, m_owner, m_last;
  int          m_busy_n;
  logic [DW-1:0] m_rdata;
  logic        m_bwe;
  logic [AW-1:0] m_baddr;
  logic [DW-1:0] m_bwdata;
  logic [MW-1:0] m_bmask;

  function automatic bit pick(input bit f, input bit m, input bit last);
    if (f && m) return !last;
    return m;
  endfunction

  always @(posedge i_clk) begin
    if (!i_reset) begin
      m_active <= 0; m_done <= 0; m_fault <= 0; m_owner <= 0; m_last <= 0;
      m_busy_n <= 0; m_rdata <= '0;
      m_bwe <= 0; m_baddr <= '0; m_bwdata <= '0; m_bmask <= '0;
    end else if (m_done) begin
      if (!(m_owner ? i_mem_req : i_fetch_req)) begin
        m_done  <= 0;
        m_fault <= 0;
      end
    end else if (m_active) begin
      m_busy_n <= m_busy_n + 1;
      if (i_bus_ack) begin
        m_active <= 0; m_done <= 1; m_rdata <= i_bus_rdata;
      end else if (m_busy_n + 1 == TMO) begin
        m_active <= 0; m_done <= 1; m_fault <= 1;
      end
    end else if (i_fetch_req || i_mem_req) begin
      m_owner  <= pick(i_fetch_req, i_mem_req, m_last);
      m_last   <= pick(i_fetch_req, i_mem_req, m_last);
      m_active <= 1;
      m_busy_n <= 0;
      if (pick(i_fetch_req, i_mem_req, m_last)) begin
        m_bwe <= i_mem_we; m_baddr <= i_mem_addr; m_bwdata <= i_mem_wdata; m_bmask <= i_mem_mask;
      end else begin
        m_bwe <= 0; m_baddr <= i_fetch_addr; m_bwdata <= '0; m_bmask <= '0;
      end
    end
  end

  always @(negedge i_clk) begin
    if (chk_on) begin
      chk("bus_req",     64'(o_bus_req),     64'(m_active));
      chk("fetch_done",  64'(o_fetch_done),  64'(m_done && !m_owner));
      chk("mem_done",    64'(o_mem_done),    64'(m_done && m_owner));
      chk("fault",       64'(o_fault),       64'(m_done && m_fault));
      chk("fetch_rdata", 64'(o_fetch_rdata), 64'((m_done && !m_fault && !m_owner) ? m_rdata : '0));
      chk("mem_rdata",   64'(o_mem_rdata),   64'((m_done && !m_fault && m_owner) ? m_rdata : '0));
      if (m_active) begin
        chk("bus_we",    64'(o_bus_we),    64'(m_bwe));
        chk("bus_addr",  64'(o_bus_addr),  64'(m_baddr));
        chk("bus_wdata", 64'(o_bus_wdata), 64'(m_bwdata));
        chk("bus_mask",  64'(o_bus_mask),  64'(m_bmask));
      end
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      #2;
    end
  endtask

  task automatic pulse_reset();
    i_reset = 1'b0;
    step();
    i_reset = 1'b1;
  endtask

  initial begin
    i_reset = 0; i_fetch_req = 0; i_fetch_addr = '0; i_mem_req = 0; i_mem_we = 0;
    i_mem_addr = '0; i_mem_wdata = '0; i_mem_mask = '0; i_bus_ack = 0; i_bus_rdata = '0;
    step(3);
    chk_on = 1'b1;
    chk("rst_bus_req", 64'(o_bus_req), 64'd0);
    chk("rst_done",    64'({o_fetch_done, o_mem_done, o_fault}), 64'd0);
    chk("rst_bus",     64'({o_bus_we, o_bus_addr, o_bus_mask}), 64'd0);
    i_reset = 1;

    // Fetch read, ack in cycle 3.
    i_fetch_req = 1; i_fetch_addr = 32'h100;
    step();
    chk("t1_c1_bus_req", 64'(o_bus_req), 64'd1);
    chk("t1_c1_addr",    64'(o_bus_addr), 64'h100);
    step(2);
    chk("t1_c3_bus_req", 64'(o_bus_req), 64'd1);
    i_bus_ack = 1; i_bus_rdata = 32'hDEADBEEF;
    step();
    i_bus_ack = 0; i_bus_rdata = '0;
    chk("t1_c4_done",  64'(o_fetch_done), 64'd1);
    chk("t1_c4_rdata", 64'(o_fetch_rdata), 64'hDEADBEEF);
    chk("t1_c4_bus_req", 64'(o_bus_req), 64'd0);
    step();
    chk("t1_c5_done", 64'(o_fetch_done), 64'd1);
    i_fetch_req = 0;
    step();
    chk("t1_c6_done", 64'(o_fetch_done), 64'd0);

    // Store.
    i_mem_req = 1; i_mem_we = 1; i_mem_addr = 32'h2000; i_mem_wdata = 32'h12345678; i_mem_mask = 4'b0011;
    step();
    chk("t2_we",    64'(o_bus_we), 64'd1);
    chk("t2_addr",  64'(o_bus_addr), 64'h2000);
    chk("t2_wdata", 64'(o_bus_wdata), 64'h12345678);
    chk("t2_mask",  64'(o_bus_mask), 64'b0011);
    step();
    i_bus_ack = 1;
    step();
    i_bus_ack = 0;
    chk("t2_mem_done",   64'(o_mem_done), 64'd1);
    chk("t2_fetch_done", 64'(o_fetch_done), 64'd0);
    i_mem_req = 0; i_mem_we = 0;
    step(2);

    // Ack while idle, then ack in the very first BUSY cycle.
    i_bus_ack = 1;
    step(2);
    chk("t7_idle_ack", 64'({o_bus_req, o_fetch_done, o_mem_done}), 64'd0);
    i_bus_ack = 0;
    i_fetch_req = 1; i_fetch_addr = 32'h140;
    step();
    i_bus_ack = 1; i_bus_rdata = 32'h0BADF00D;
    step();
    i_bus_ack = 0;
    chk("t7_fast_done",  64'(o_fetch_done), 64'd1);
    chk("t7_fast_rdata", 64'(o_fetch_rdata), 64'h0BADF00D);
    i_fetch_req = 0;
    step(2);

    // Contention after reset: mem first, then alternating.
    pulse_reset();
    i_fetch_req = 1; i_fetch_addr = 32'h300;
    i_mem_req = 1; i_mem_we = 0; i_mem_addr = 32'h4000; i_mem_mask = '0; i_mem_wdata = '0;
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < 12 && !o_bus_req; w++) step();
      chk("rr_bus_req", 64'(o_bus_req), 64'd1);
      chk("rr_addr", 64'(o_bus_addr), (k % 2 == 0) ? 64'h4000 : 64'h300);
      i_bus_ack = 1; i_bus_rdata = 32'hA0 + 32'(k);
      step();
      i_bus_ack = 0;
      chk("rr_mem_done",   64'(o_mem_done),   64'(k % 2 == 0));
      chk("rr_fetch_done", 64'(o_fetch_done), 64'(k % 2 == 1));
      if (k % 2 == 0) i_mem_req = 0; else i_fetch_req = 0;
      step();
      chk("rr_gap_done", 64'({o_fetch_done, o_mem_done, o_bus_req}), 64'd0);
      i_mem_req = 1; i_fetch_req = 1;
    end
    i_mem_req = 0; i_fetch_req = 0;
    step(12);
    i_bus_ack = 1;
    step();
    i_bus_ack = 0;
    step(3);
    for (int w = 0; w < 6 && (o_fetch_done || o_mem_done); w++) step();

    // Watchdog expiry with a late ack.
    pulse_reset();
    i_mem_req = 1; i_mem_we = 0; i_mem_addr = 32'h5000;
    step();
    for (int c = 1; c <= 4; c++) begin
      chk("t4_busy", 64'(o_bus_req), 64'd1);
      step();
    end
    chk("t4_fault",    64'(o_fault), 64'd1);
    chk("t4_mem_done", 64'(o_mem_done), 64'd1);
    chk("t4_bus_req",  64'(o_bus_req), 64'd0);
    chk("t4_rdata",    64'(o_mem_rdata), 64'd0);
    i_bus_ack = 1; i_bus_rdata = 32'hFFFF;
    step();
    i_bus_ack = 0;
    chk("t4_late_ack", 64'({o_fault, o_mem_rdata}), 64'h1_0000_0000);
    i_mem_req = 0;
    step();
    chk("t4_exit", 64'({o_fault, o_mem_done}), 64'd0);

    // Ack on the last allowed BUSY cycle completes normally.
    i_mem_req = 1;
    step(4);
    i_bus_ack = 1; i_bus_rdata = 32'h5A5A;
    step();
    i_bus_ack = 0;
    chk("t5_done",  64'(o_mem_done), 64'd1);
    chk("t5_fault", 64'(o_fault), 64'd0);
    chk("t5_rdata", 64'(o_mem_rdata), 64'h5A5A);
    i_mem_req = 0;
    step(2);

    // Reset while BUSY with a simultaneous ack.
    i_fetch_req = 1; i_fetch_addr = 32'h700;
    step(2);
    i_reset = 0; i_bus_ack = 1; i_bus_rdata = 32'h1234;
    step();
    chk("t6_bus_req", 64'(o_bus_req), 64'd0);
    chk("t6_done",    64'({o_fetch_done, o_mem_done, o_fault}), 64'd0);
    chk("t6_bus",     64'({o_bus_we, o_bus_addr, o_bus_mask}), 64'd0);
    chk("t6_rdata",   64'(o_fetch_rdata), 64'd0);
    i_reset = 1; i_bus_ack = 0; i_fetch_req = 0;
    step(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
